paso8bto32b: RTL and testbench

Byte-to-word reassembly stage on the receive side of the 32-bit/8-bit lane path. It consumes the byte stream produced by the 32-bit-to-8-bit stage (four bytes per word, MSB byte first, one byte per `clk_4f` cycle under `valid`) and rebuilds the 32-bit word. It flags and discards incomplete words. Runs entirely in the `clk_4f` domain; any retiming to `clk_f` is done downstream.

---
 rtl/paso8bto32b_pkg.sv | 16 +
 rtl/paso8bto32b.sv | 76 +++++++
 tb/tb_paso8bto32b.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/paso8bto32b_pkg.sv
// Shared lane-path constants for the 32-bit <-> 8-bit stages.
//   BYTE_W         : width of one lane byte
//   WORD_W         : width of a reassembled word
//   BYTES_PER_WORD : bytes per word
//   ACC_W          : width of the partial-word accumulator (all but the last byte)
//   LAST_BYTE      : byte_cnt value while waiting for the final byte of a word
package paso8bto32b_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ACC_W          = WORD_W - BYTE_W;

  localparam logic [1:0]  LAST_BYTE      = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/paso8bto32b.sv
// Byte-to-word reassembly stage (clk_4f domain).
// Rebuilds 32-bit words from a stream of four bytes per word; a word that is
// interrupted by a gap in valid_in is discarded and flagged on err_out.
// Ports:
//   clk_4f     in   byte-rate clock, rising edge
//   reset      in   synchronous active-high reset
//   data_in    in   incoming byte
//   valid_in   in   data_in carries a byte this cycle
//   data_out   out  last completed word, held until the next completes
//   valid_out  out  one-cycle strobe: data_out updated
//   err_out    out  one-cycle strobe: partial word (1-3 bytes) discarded
//   byte_cnt   out  bytes of the current word already captured
// Parameter MSB_FIRST: 1 puts the first byte in [31:24], 0 puts it in [7:0].
module paso8bto32b
  import paso8bto32b_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              err_out,
  output logic [1:0]        byte_cnt
);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [1:0]        slot;
  logic [WORD_W-1:0] word;

  // Accumulator slot for the incoming byte: MSB-first fills from the top
  // down, LSB-first fills from the bottom up.
  always_comb begin
    slot     = MSB_FIRST ? (2'd2 - byte_cnt) : byte_cnt;
    acc_next = acc;
    if (byte_cnt != LAST_BYTE) begin
      acc_next[{slot, 3'b000} +: BYTE_W] = data_in;
    end
  end

  always_comb begin
    word = MSB_FIRST ? {acc, data_in} : {data_in, acc};
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      acc       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      if (valid_in) begin
        if (byte_cnt == LAST_BYTE) begin
          data_out  <= word;
          valid_out <= 1'b1;
          byte_cnt  <= '0;
        end else begin
          acc      <= acc_next;
          byte_cnt <= byte_cnt + 2'd1;
        end
      end else if (byte_cnt != 2'd0) begin
        // Gap inside a word: drop it; stale accumulator bytes are overwritten
        // by the next word before they can be used.
        err_out  <= 1'b1;
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_paso8bto32b.sv
module tb_paso8bto32b;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;

  logic [31:0] m_data_out, l_data_out;
  logic        m_valid_out, l_valid_out;
  logic        m_err_out, l_err_out;
  logic [1:0]  m_byte_cnt, l_byte_cnt;

  int unsigned n_checks = 0;
  int unsigned n_passed = 0;

  // reference model state: bytes of the word in progress, in arrival order
  logic [7:0]  q[$];
  logic [31:0] exp_m_word = '0;
  logic [31:0] exp_l_word = '0;
  logic        exp_valid  = 1'b0;
  logic        exp_err    = 1'b0;

  always #5 clk_4f = ~clk_4f;

  paso8bto32b #(.MSB_FIRST(1'b1)) u_msb (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out(m_data_out), .valid_out(m_valid_out), .err_out(m_err_out),
    .byte_cnt(m_byte_cnt)
  );

  paso8bto32b #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out(l_data_out), .valid_out(l_valid_out), .err_out(l_err_out),
    .byte_cnt(l_byte_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clk_4f cycle: drive, update the model, then compare every output.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    reset    = r;
    valid_in = v;
    data_in  = d;
    if (r) begin
      q.delete();
      exp_m_word = '0;
      exp_l_word = '0;
      exp_valid  = 1'b0;
      exp_err    = 1'b0;
    end else if (v) begin
      exp_err = 1'b0;
      if (q.size() == 3) begin
        exp_m_word = {q[0], q[1], q[2], d};
        exp_l_word = {d, q[2], q[1], q[0]};
        exp_valid  = 1'b1;
        q.delete();
      end else begin
        q.push_back(d);
        exp_valid = 1'b0;
      end
    end else begin
      exp_valid = 1'b0;
      exp_err   = (q.size() != 0);
      q.delete();
    end
    @(posedge clk_4f);
    #1;
    chk("msb_data",  m_data_out, exp_m_word);
    chk("msb_valid", 32'(m_valid_out), 32'(exp_valid));
    chk("msb_err",   32'(m_err_out), 32'(exp_err));
    chk("msb_cnt",   32'(m_byte_cnt), 32'(q.size()));
    chk("lsb_data",  l_data_out, exp_l_word);
    chk("lsb_valid", 32'(l_valid_out), 32'(exp_valid));
    chk("lsb_err",   32'(l_err_out), 32'(exp_err));
    chk("lsb_cnt",   32'(l_byte_cnt), 32'(q.size()));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) step(1'b1, w[31 - 8*i -: 8], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    idle(2);

    // single word, MSB-first
    send_word(32'hABCDEFFF);
    chk("first_word_const", m_data_out, 32'hABCDEFFF);
    chk("first_word_strobe", 32'(m_valid_out), 32'd1);
    idle(1);

    // back-to-back words
    send_word(32'hABCDEFFF);
    send_word(32'hADBDCDDD);
    chk("b2b_second_const", m_data_out, 32'hADBDCDDD);
    idle(2);

    // partial word then a clean word
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("partial_err_const", 32'(m_err_out), 32'd1);
    chk("partial_hold_const", m_data_out, 32'hADBDCDDD);
    send_word(32'h01020403);
    chk("after_partial_const", m_data_out, 32'h01020403);

    // reset after three bytes, then a full word
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    send_word(32'hCAFEF00D);

    // LSB-first ordering: FF EF CD AB assembles to ABCDEFFF
    send_word(32'hFFEFCDAB);
    chk("lsb_order_const", l_data_out, 32'hABCDEFFF);

    // loopback-style traffic with an idle word slot
    send_word(32'hABCDEFFF);
    send_word(32'hADBDCDDD);
    idle(4);
    send_word(32'h01020403);
    step(1'b1, 8'h77, 1'b0);
    step(1'b1, 8'h88, 1'b1);  // reset takes priority over a valid byte

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 8), 8'($urandom), ($urandom_range(0, 59) == 0));
    end
    // gap after exactly three bytes
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
